// File: rtl/multicycle_ctrl_fsm_if.sv
// rtl/multicycle_ctrl_fsm_if.sv - control bundle between the multi-cycle FSM and the RV32I datapath.
interface multicycle_ctrl_fsm_if #(
    parameter int RET_W = 32
);
    logic [6:0]       op;
    logic             mem_ready;
    logic             zero;
    logic             irwrite;
    logic             pcwrite;
    logic             adrsrc;
    logic [1:0]       alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       alu_op;
    logic [1:0]       immsrc;
    logic [1:0]       resultsrc;
    logic             memwrite;
    logic             regwrite;
    logic             illegal;
    logic             instr_done;
    logic [RET_W-1:0] retired;

    modport master (
        input  op, mem_ready, zero,
        output irwrite, pcwrite, adrsrc, alusrca, alusrcb, alu_op, immsrc,
               resultsrc, memwrite, regwrite, illegal, instr_done, retired
    );

    modport slave (
        output op, mem_ready, zero,
        input  irwrite, pcwrite, adrsrc, alusrca, alusrcb, alu_op, immsrc,
               resultsrc, memwrite, regwrite, illegal, instr_done, retired
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - Moore control FSM for a multi-cycle RV32I datapath.
// Outputs decode from state only, except the MEM_READY/Zero gated PC/IR strobes.
module multicycle_ctrl_fsm #(
    parameter int RET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_ctrl_fsm_if.master bus
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, ALUWB_J, BEQ, JAL, TRAP
    } state_t;

    state_t           state, state_nx;
    logic [RET_W-1:0] retired_q;

    logic       irwrite, pcwrite, adrsrc, memwrite, regwrite, illegal, instr_done;
    logic [1:0] alusrca, alusrcb, alu_op, immsrc, resultsrc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nx;
    end

    // Retired wraps naturally at 2^RET_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             retired_q <= '0;
        else if (instr_done) retired_q <= retired_q + 1'b1;
    end

    always_comb begin
        immsrc = 2'b00;
        case (bus.op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    always_comb begin
        state_nx   = state;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        adrsrc     = 1'b0;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        alu_op     = 2'b00;
        resultsrc  = 2'b00;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state)
            FETCH: begin
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = bus.mem_ready;
                pcwrite   = bus.mem_ready;
                if (bus.mem_ready) state_nx = DECODE;
            end
            DECODE: begin
                // PC-relative target parked in ALUOut for beq/jal.
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_nx = MEMADR;
                    OP_R:         state_nx = EXECR;
                    OP_I:         state_nx = EXECI;
                    OP_BEQ:       state_nx = BEQ;
                    OP_JAL:       state_nx = JAL;
                    default:      state_nx = TRAP;
                endcase
            end
            MEMADR: begin
                alusrca  = 2'b10;
                alusrcb  = 2'b01;
                state_nx = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adrsrc = 1'b1;
                if (bus.mem_ready) state_nx = MEMWB;
            end
            MEMWB: begin
                resultsrc  = 2'b01;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_nx   = FETCH;
            end
            MEMWRITE: begin
                adrsrc     = 1'b1;
                memwrite   = 1'b1;
                instr_done = bus.mem_ready;
                if (bus.mem_ready) state_nx = FETCH;
            end
            EXECR: begin
                alusrca  = 2'b10;
                alu_op   = 2'b10;
                state_nx = ALUWB;
            end
            EXECI: begin
                alusrca  = 2'b10;
                alusrcb  = 2'b01;
                alu_op   = 2'b10;
                state_nx = ALUWB;
            end
            ALUWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_nx   = FETCH;
            end
            ALUWB_J: begin
                // Link write for jal; the instruction already retired in JAL.
                regwrite = 1'b1;
                state_nx = FETCH;
            end
            BEQ: begin
                alusrca    = 2'b10;
                alu_op     = 2'b01;
                pcwrite    = bus.zero;
                instr_done = 1'b1;
                state_nx   = FETCH;
            end
            JAL: begin
                alusrca    = 2'b01;
                alusrcb    = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
                state_nx   = ALUWB_J;
            end
            TRAP: begin
                illegal  = 1'b1;
                state_nx = TRAP;
            end
            default: state_nx = FETCH;
        endcase
    end

    assign bus.irwrite    = irwrite;
    assign bus.pcwrite    = pcwrite;
    assign bus.adrsrc     = adrsrc;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.alu_op     = alu_op;
    assign bus.immsrc     = immsrc;
    assign bus.resultsrc  = resultsrc;
    assign bus.memwrite   = memwrite;
    assign bus.regwrite   = regwrite;
    assign bus.illegal    = illegal;
    assign bus.instr_done = instr_done;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - self-checking bench for multicycle_ctrl_fsm (32-bit and 4-bit counters).
module tb_multicycle_ctrl_fsm;
    localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, ER = 6, EI = 7;
    localparam int AW = 8, AWJ = 9, BQ = 10, JL = 11, TR = 12;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1110011;

    typedef struct {
        logic [6:0] op;
        logic       zero;
        int         fstall;
        int         mstall;
    } vec_t;

    typedef struct {
        int          st;
        logic        mr;
        logic        zero;
        logic [16:0] exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.RET_W(32)) b ();
    multicycle_ctrl_fsm_if #(.RET_W(4))  b4 ();

    assign b4.op        = b.op;
    assign b4.mem_ready = b.mem_ready;
    assign b4.zero      = b.zero;

    multicycle_ctrl_fsm #(.RET_W(32)) dut   (.clk(clk), .rst(rst), .bus(b));
    multicycle_ctrl_fsm #(.RET_W(4))  dut_w (.clk(clk), .rst(rst), .bus(b4));

    int          checks   = 0;
    int          failures = 0;
    int          ret_model = 0;
    int          done_seen = 0;
    sb_t         sbq[$];
    vec_t        vecs[10];

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        case (op)
            OP_SW:   return 2'b01;
            OP_BEQ:  return 2'b10;
            OP_JAL:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // {irwrite,pcwrite,adrsrc,alusrca,alusrcb,alu_op,immsrc,resultsrc,memwrite,regwrite,illegal,instr_done}
    function automatic logic [16:0] exp_out(input int st, input logic mr, input logic z, input logic [1:0] imm);
        logic       irw = 0, pcw = 0, adr = 0, mw = 0, rw = 0, ill = 0, dn = 0;
        logic [1:0] a = 0, bb = 0, aop = 0, rs = 0;
        case (st)
            F:   begin bb = 2; rs = 2; irw = mr; pcw = mr; end
            D:   begin a = 1; bb = 1; end
            MA:  begin a = 2; bb = 1; end
            MR:  begin adr = 1; end
            MWB: begin rs = 1; rw = 1; dn = 1; end
            MW:  begin adr = 1; mw = 1; dn = mr; end
            ER:  begin a = 2; aop = 2; end
            EI:  begin a = 2; bb = 1; aop = 2; end
            AW:  begin rw = 1; dn = 1; end
            AWJ: begin rw = 1; end
            BQ:  begin a = 2; aop = 1; pcw = z; dn = 1; end
            JL:  begin a = 1; bb = 2; pcw = 1; dn = 1; end
            TR:  begin ill = 1; end
            default: ;
        endcase
        return {irw, pcw, adr, a, bb, aop, imm, rs, mw, rw, ill, dn};
    endfunction

    function automatic logic [16:0] act_word();
        return {b.irwrite, b.pcwrite, b.adrsrc, b.alusrca, b.alusrcb, b.alu_op, b.immsrc,
                b.resultsrc, b.memwrite, b.regwrite, b.illegal, b.instr_done};
    endfunction

    task automatic chk(input string name, input logic [16:0] expw);
        logic [3:0] r4;
        r4 = ret_model[3:0];
        checks++;
        if (act_word() !== expw || b.retired !== ret_model || b4.retired !== r4) begin
            failures++;
            $display("FAIL %s: ctrl=%h required=%h retired=%0d/%0d required=%0d/%0d",
                     name, act_word(), expw, b.retired, b4.retired, ret_model, r4);
        end
    endtask

    task automatic chk_eq(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got=%0d required=%0d", name, act, expv);
        end
    endtask

    task automatic push(input int st, input logic mr, input logic z, input logic [6:0] op);
        sb_t e;
        e.st = st; e.mr = mr; e.zero = z;
        e.exp = exp_out(st, mr, z, imm_of(op));
        sbq.push_back(e);
    endtask

    // Drains the scoreboard one cycle per entry; entered and left at posedge+1.
    task automatic drain(input string name, input logic [6:0] op);
        sb_t e;
        int  cyc = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            b.op = op; b.mem_ready = e.mr; b.zero = e.zero;
            @(negedge clk);
            chk($sformatf("%s_c%0d", name, cyc), e.exp);
            if (b.instr_done) done_seen++;
            if (e.exp[0]) ret_model++;
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic build(input logic [6:0] op, input logic z, input int fs, input int ms);
        for (int i = 0; i < fs; i++) push(F, 1'b0, 1'($urandom), op);
        push(F, 1'b1, 1'($urandom), op);
        push(D, 1'($urandom), 1'($urandom), op);
        case (op)
            OP_LW: begin
                push(MA, 1'($urandom), 1'($urandom), op);
                for (int i = 0; i < ms; i++) push(MR, 1'b0, 1'($urandom), op);
                push(MR, 1'b1, 1'($urandom), op);
                push(MWB, 1'($urandom), 1'($urandom), op);
            end
            OP_SW: begin
                push(MA, 1'($urandom), 1'($urandom), op);
                for (int i = 0; i < ms; i++) push(MW, 1'b0, 1'($urandom), op);
                push(MW, 1'b1, 1'($urandom), op);
            end
            OP_R:   begin push(ER, 1'($urandom), 1'($urandom), op); push(AW, 1'($urandom), 1'($urandom), op); end
            OP_I:   begin push(EI, 1'($urandom), 1'($urandom), op); push(AW, 1'($urandom), 1'($urandom), op); end
            OP_BEQ: push(BQ, 1'($urandom), z, op);
            OP_JAL: begin push(JL, 1'($urandom), 1'($urandom), op); push(AWJ, 1'($urandom), 1'($urandom), op); end
            default: for (int i = 0; i < 20; i++) push(TR, 1'($urandom), 1'($urandom), op);
        endcase
    endtask

    task automatic run_instr(input string name, input logic [6:0] op, input logic z, input int fs, input int ms);
        int d0, r0;
        d0 = done_seen;
        r0 = b.retired;
        build(op, z, fs, ms);
        drain(name, op);
        chk_eq({name, "_pulses"}, done_seen - d0, 1);
        chk_eq({name, "_retired_delta"}, b.retired - r0, 1);
    endtask

    task automatic reset_and_check(input string name);
        rst = 1'b1;
        b.mem_ready = 1'b0;
        ret_model = 0;
        #1;
        chk({name, "_async"}, exp_out(F, 1'b0, 1'b0, imm_of(b.op)));
        @(negedge clk);
        chk({name, "_held"}, exp_out(F, 1'b0, 1'b0, imm_of(b.op)));
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{OP_LW,  1'b0, 0, 0};
        vecs[1] = '{OP_SW,  1'b0, 0, 0};
        vecs[2] = '{OP_R,   1'b0, 0, 0};
        vecs[3] = '{OP_I,   1'b0, 0, 0};
        vecs[4] = '{OP_BEQ, 1'b1, 0, 0};
        vecs[5] = '{OP_JAL, 1'b0, 0, 0};
        vecs[6] = '{OP_LW,  1'b0, 0, 3};
        vecs[7] = '{OP_BEQ, 1'b0, 0, 0};
        vecs[8] = '{OP_SW,  1'b0, 1, 2};
        vecs[9] = '{OP_R,   1'b1, 2, 0};

        b.op = OP_R; b.mem_ready = 1'b0; b.zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", exp_out(F, 1'b0, 1'b0, 2'b00));
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_instr($sformatf("vec%0d_op%b", i, vecs[i].op), vecs[i].op, vecs[i].zero,
                      vecs[i].fstall, vecs[i].mstall);
            if (i == 5) chk_eq("retired_after_six", b.retired, 6);
        end

        // Reset while MEMWRITE is stalled
        push(F, 1'b1, 1'b0, OP_SW);
        push(D, 1'b1, 1'b0, OP_SW);
        push(MA, 1'b1, 1'b0, OP_SW);
        push(MW, 1'b0, 1'b0, OP_SW);
        push(MW, 1'b0, 1'b0, OP_SW);
        drain("sw_stall", OP_SW);
        reset_and_check("rst_mid_memwrite");
        chk_eq("rst_illegal", b.illegal, 0);

        // Illegal opcode: DECODE then 20 cycles of TRAP
        build(OP_BAD, 1'b0, 0, 0);
        drain("illegal", OP_BAD);
        chk_eq("illegal_sticky", b.illegal, 1);
        reset_and_check("rst_after_trap");
        chk_eq("illegal_cleared", b.illegal, 0);

        // Counter wrap on the 4-bit instance
        for (int i = 0; i < 17; i++) run_instr($sformatf("wrap%0d", i), OP_R, 1'b0, 0, 0);
        chk_eq("wrap_ret4", b4.retired, 1);
        chk_eq("wrap_ret32", b.retired, 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Moore control FSM that sequences a multi-cycle RV32I datapath: one shared memory port, one ALU, and instruction/data/ALUOut holding registers.
- Supports the same opcode subset as the pipeline decoder: lw, sw, R-type, I-type ALU, beq and jal.
- Adds a memory-ready handshake, illegal-opcode trapping and a retired-instruction counter.
- Sits between the instruction register (OP field) and the datapath enables and muxes.

Parameters:
RET_W, 32, width of the retired-instruction counter

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-high reset
OP  input  7  opcode from the instruction register
MEM_READY  input  1  memory has completed the current access
Zero  input  1  ALU zero flag
IRWrite  output  1  load the instruction register
PCWrite  output  1  load the PC (PCUpdate, or Branch and Zero)
AdrSrc  output  1  0: memory address = PC; 1: memory address = Result
ALUSrcA  output  2  00 PC, 01 OldPC, 10 RD1
ALUSrcB  output  2  00 RD2, 01 Imm, 10 constant 4
ALU_OP  output  2  00 add, 01 sub/compare, 10 funct-decoded
IMMSRC  output  2  00 I, 01 S, 10 B, 11 J
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
MemWrite  output  1  memory write strobe
REGWRITE  output  1  register file write enable
Illegal  output  1  sticky flag: unsupported opcode fetched
Instr_Done  output  1  one-cycle pulse when an instruction retires
Retired  output  RET_W  count of retired instructions

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- RST asserted, at any time including mid-instruction: state goes to FETCH immediately.
  - Retired=0, Illegal=0, Instr_Done=0.
  - Outputs immediately take their FETCH values, listed below.
- Control outputs are decoded from the state only.
  - Exceptions: IRWrite and PCWrite in FETCH are gated by MEM_READY; PCWrite in BEQ is gated by Zero.
  - Any output not listed for a state is 0.
- IMMSRC is decoded combinationally from OP in every state, using the codes above.
  - An unsupported opcode gives IMMSRC=00.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU_OP=00, ResultSrc=10.
  - IRWrite=PCWrite=MEM_READY.
  - Stays in FETCH while MEM_READY=0; otherwise goes to DECODE.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALU_OP=00 (computes branch/jump target into ALUOut).
  - Next state by OP: lw or sw -> MEMADR; R-type -> EXECR; I-type ALU -> EXECI; beq -> BEQ; jal -> JAL; any other value -> TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALU_OP=00. Next state: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Holds until MEM_READY=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, REGWRITE=1, Instr_Done=1. Next state: FETCH.
- MEMWRITE:
  - ResultSrc=00, AdrSrc=1, MemWrite=1, held for the whole state.
  - Holds until MEM_READY=1. On that cycle Instr_Done=1, then goes to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALU_OP=10. Next state: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALU_OP=10. Next state: ALUWB.
- ALUWB: ResultSrc=00, REGWRITE=1, Instr_Done=1. Next state: FETCH.
- BEQ:
  - ALUSrcA=10, ALUSrcB=00, ALU_OP=01, ResultSrc=00.
  - PCWrite=Zero, Instr_Done=1. Next state: FETCH.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, ALU_OP=00, ResultSrc=00.
  - PCWrite=1, Instr_Done=1. Next state: ALUWB_J, which shares ALUWB outputs except that Instr_Done=0 there; then FETCH.
- TRAP:
  - All strobes 0, Illegal=1.
  - Absorbing state: it is left only via RST.
- Retired increments by 1 on every cycle with Instr_Done=1, and wraps modulo 2^RET_W.
- Cycle counts with MEM_READY held at 1:
  - lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4 (FETCH through the last state).
- Each MEM_READY=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
  - MemWrite is never deasserted during a stall.
- MEM_READY is ignored in every state other than FETCH, MEMREAD and MEMWRITE.

Test Plan:
- Reset check: assert RST mid-MEMWRITE with MEM_READY=0 -> next sample shows FETCH outputs (ALUSrcB=10, ResultSrc=10, MemWrite=0), Retired=0, Illegal=0.
- Per-opcode sequences, MEM_READY=1: apply OP = 0000011, 0100011, 0110011, 0010011, 1100011, 1101111 -> durations 5/4/4/4/3/4 cycles, exact per-state outputs, one Instr_Done pulse each, Retired=6.
- lw with memory wait: MEM_READY=0 for 3 cycles in MEMREAD -> lw takes 8 cycles, REGWRITE only in MEMWB.
- Branch resolution: beq with Zero=1 -> PCWrite=1 in BEQ. Zero=0 -> PCWrite=0, and the FSM still returns to FETCH.
- Illegal opcode: OP=7'b1110011 -> DECODE then TRAP, Illegal=1 held for 20 cycles with no strobes; RST clears it.
- Counter wrap: RET_W=4, retire 17 R-type instructions -> Retired=1.
